router_ctrl: RTL and testbench

Packet-level controller for the 1x3 router.
- Accepts a byte stream from the source, decodes the header address and sequences writes into one of three router_fifo instances.
- Drives write_enb, lfd_state and the FIFO write data; computes and checks packet parity.
- Generates per-FIFO valid flags and soft-reset timeouts for unread output ports.

---
 rtl/router_pkg.sv | 36 +++
 rtl/router_if.sv | 30 +++
 rtl/router_timeout.sv | 48 ++++
 rtl/router_ctrl.sv | 174 +++++++++++++++++
 tb/tb_router_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router controller.
//   state_e      : controller FSM states
//   NUM_PORTS    : number of output FIFOs
//   ADDR_INVALID : header destination value that is never routed
//   HDR_*        : header field bit positions ([7:2] length, [1:0] destination)
//   dest_onehot  : destination address to one-hot port select (zero for the invalid address)
package router_pkg;

    localparam int unsigned NUM_PORTS    = 3;
    localparam logic [1:0]  ADDR_INVALID = 2'b11;

    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned HDR_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        StIdle,
        StWaitEmpty,
        StHeader,
        StPayload,
        StParity,
        StCheck,
        StDrop
    } state_e;

    function automatic logic [NUM_PORTS-1:0] dest_onehot(input logic [1:0] addr);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        if (addr != ADDR_INVALID) begin
            oh[addr] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/router_if.sv
// Source/FIFO-side signal bundle of the router controller.
//   slave  : controller view (takes the source byte stream and FIFO status, drives FIFO writes)
//   master : environment view (source, FIFOs and downstream readers)
interface router_if;
    import router_pkg::*;

    logic                 pkt_valid;
    logic [7:0]           data_in;
    logic                 busy;
    logic                 err;
    logic [7:0]           fifo_din;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 lfd_state;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] read_enb;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;

    modport master (
        output pkt_valid, data_in, full, empty, read_enb,
        input  busy, err, fifo_din, write_enb, lfd_state, vld_out, soft_reset
    );

    modport slave (
        input  pkt_valid, data_in, full, empty, read_enb,
        output busy, err, fifo_din, write_enb, lfd_state, vld_out, soft_reset
    );

endinterface

// File: rtl/router_timeout.sv
// Per-port unread timeout: counts consecutive cycles where the port holds data and is not
// read; on the TIMEOUT-th such cycle it pulses soft_reset_o for one cycle and restarts.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   vld_i        : port has data (vld_out)
//   read_enb_i   : downstream read enable
//   soft_reset_o : registered one-cycle soft-reset pulse
module router_timeout #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vld_i,
    input  logic read_enb_i,
    output logic soft_reset_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             srst_q, srst_d;

    always_comb begin
        cnt_d  = '0;
        srst_d = 1'b0;
        if (vld_i && !read_enb_i) begin
            if (cnt_q == LastCnt) begin
                srst_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            srst_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            srst_q <= srst_d;
        end
    end

    assign soft_reset_o = srst_q;

endmodule

// File: rtl/router_ctrl.sv
// Packet-level controller of the 1x3 router. Decodes the header of each source packet,
// waits for the destination FIFO to drain, then sequences header, payload and parity
// writes into it while accumulating and checking parity. Also produces per-port valid
// flags and unread-timeout soft resets.
//   clk, resetn : clock and asynchronous active-low reset
//   bus (slave) : pkt_valid/data_in/busy source handshake, err pulse, fifo_din/write_enb/
//                 lfd_state FIFO writes, full/empty/read_enb status, vld_out, soft_reset
module router_ctrl
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic     clk,
    input  logic     resetn,
    router_if.slave  bus
);

    state_e               state_q, state_d;
    logic [7:0]           hdr_q, hdr_d;
    logic [7:0]           parity_q, parity_d;
    // Remaining payload bytes in PAYLOAD; remaining bytes including parity in DROP.
    logic [6:0]           cnt_q, cnt_d;
    logic                 mismatch_q, mismatch_d;

    logic                 busy;
    logic                 accept;
    logic [NUM_PORTS-1:0] dest_oh;
    logic                 dest_full, dest_empty, dest_srst;
    logic [6:0]           len_in, len_hdr_plus1;
    logic [NUM_PORTS-1:0] soft_reset;

    assign dest_oh    = dest_onehot(hdr_q[HDR_ADDR_MSB:HDR_ADDR_LSB]);
    assign dest_full  = |(bus.full & dest_oh);
    assign dest_empty = |(bus.empty & dest_oh);
    assign dest_srst  = |(soft_reset & dest_oh);
    assign accept     = bus.pkt_valid & ~busy;

    assign len_in        = {1'b0, bus.data_in[HDR_LEN_MSB:HDR_LEN_LSB]};
    assign len_hdr_plus1 = {1'b0, hdr_q[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        parity_d      = parity_q;
        cnt_d         = cnt_q;
        mismatch_d    = mismatch_q;
        busy          = 1'b0;
        bus.write_enb = '0;
        bus.lfd_state = 1'b0;
        bus.fifo_din  = bus.data_in;

        unique case (state_q)
            StIdle: begin
                if (accept && bus.data_in[HDR_ADDR_MSB:HDR_ADDR_LSB] != ADDR_INVALID) begin
                    hdr_d    = bus.data_in;
                    parity_d = bus.data_in;
                    cnt_d    = len_in;
                    state_d  = StWaitEmpty;
                end
            end

            StWaitEmpty: begin
                busy = 1'b1;
                if (dest_srst) begin
                    cnt_d   = len_hdr_plus1;
                    state_d = StDrop;
                end else if (dest_empty) begin
                    state_d = StHeader;
                end
            end

            StHeader: begin
                busy          = 1'b1;
                bus.write_enb = dest_oh;
                bus.lfd_state = 1'b1;
                bus.fifo_din  = hdr_q;
                if (dest_srst) begin
                    cnt_d   = len_hdr_plus1;
                    state_d = StDrop;
                end else if (cnt_q == '0) begin
                    state_d = StParity;
                end else begin
                    state_d = StPayload;
                end
            end

            StPayload: begin
                busy = dest_full;
                if (accept) begin
                    bus.write_enb = dest_oh;
                    parity_d      = parity_q ^ bus.data_in;
                    cnt_d         = cnt_q - 7'd1;
                end
                if (dest_srst) begin
                    // Bytes still owed by the source: unread payload plus parity.
                    cnt_d   = accept ? cnt_q : cnt_q + 7'd1;
                    state_d = StDrop;
                end else if (accept && cnt_q == 7'd1) begin
                    state_d = StParity;
                end
            end

            StParity: begin
                busy = dest_full;
                if (accept) begin
                    bus.write_enb = dest_oh;
                    mismatch_d    = (bus.data_in != parity_q);
                end
                if (dest_srst) begin
                    // Parity already consumed means nothing is left to discard.
                    cnt_d   = 7'd1;
                    state_d = accept ? StIdle : StDrop;
                end else if (accept) begin
                    state_d = StCheck;
                end
            end

            StCheck: begin
                busy    = 1'b1;
                state_d = StIdle;
            end

            StDrop: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else if (accept) begin
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            hdr_q      <= '0;
            parity_q   <= '0;
            cnt_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            parity_q   <= parity_d;
            cnt_q      <= cnt_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.busy    = busy;
    assign bus.err     = (state_q == StCheck) && mismatch_q;
    assign bus.vld_out = ~bus.empty;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timeout
        router_timeout #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timeout (
            .clk_i        (clk),
            .rst_ni       (resetn),
            .vld_i        (bus.vld_out[i]),
            .read_enb_i   (bus.read_enb[i]),
            .soft_reset_o (soft_reset[i])
        );
    end

    assign bus.soft_reset = soft_reset;

endmodule

// File: tb/tb_router_ctrl.sv
module tb_router_ctrl;
    import router_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    router_if bus ();

    router_ctrl #(
        .TIMEOUT (30),
        .CNT_W   (5)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic       pv;
        logic [7:0] din;
        logic [2:0] full;
        logic [2:0] empty;
        logic       busy;
        logic [2:0] we;
        logic       lfd;
        logic [7:0] fdin;
        logic       err;
    } vec_t;

    vec_t vecs [64];
    int   nvec   = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [7:0] din, input logic [2:0] full,
                       input logic [2:0] empty, input logic busy, input logic [2:0] we,
                       input logic lfd, input logic [7:0] fdin, input logic err);
        vecs[nvec] = '{pv, din, full, empty, busy, we, lfd, fdin, err};
        nvec++;
    endtask

    // Called just after a rising edge; returns just after the next one.
    // Compared word: {busy, write_enb, lfd_state, err, fifo_din (writes only), vld_out}.
    task automatic apply(input int i, output logic [2:0] we_obs);
        logic [7:0] din_m;
        bus.pkt_valid = vecs[i].pv;
        bus.data_in   = vecs[i].din;
        bus.full      = vecs[i].full;
        bus.empty     = vecs[i].empty;
        bus.read_enb  = 3'b000;
        @(negedge clk);
        we_obs = bus.write_enb;
        din_m  = (vecs[i].we != 3'b000) ? bus.fifo_din : 8'h00;
        check($sformatf("vec%0d", i),
              {15'd0, bus.busy, bus.write_enb, bus.lfd_state, bus.err, din_m, bus.vld_out},
              {15'd0, vecs[i].busy, vecs[i].we, vecs[i].lfd, vecs[i].err, vecs[i].fdin,
               ~vecs[i].empty});
        @(posedge clk);
        #1;
    endtask

    task automatic run_timeout(input string name, input int rd_cycle, input int exp_cycle,
                               input int ncyc);
        int first  = 0;
        int pulses = 0;
        int stray  = 0;
        bus.pkt_valid = 1'b0;
        bus.full      = 3'b000;
        bus.empty     = 3'b111;
        bus.read_enb  = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        bus.empty    = 3'b110;
        bus.read_enb = (rd_cycle == 1) ? 3'b001 : 3'b000;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (bus.soft_reset[0]) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (bus.soft_reset[2:1] != 2'b00) stray++;
            @(posedge clk);
            #1;
            bus.read_enb = (k + 1 == rd_cycle) ? 3'b001 : 3'b000;
        end
        check({name, "_cycle"}, first, exp_cycle);
        check({name, "_pulses"}, pulses, 1);
        check({name, "_other_ports"}, stray, 0);
        bus.empty = 3'b111;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] we_obs;
        int         wr;

        // Packet 1: port 1, LEN 3, correct parity 0x0D
        add(1, 8'h0D, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);
        add(1, 8'h11, 3'b000, 3'b111, 1, 3'b000, 0, 8'h00, 0);
        add(1, 8'h11, 3'b000, 3'b111, 1, 3'b010, 1, 8'h0D, 0);
        add(1, 8'h11, 3'b000, 3'b111, 0, 3'b010, 0, 8'h11, 0);
        add(1, 8'h22, 3'b000, 3'b111, 0, 3'b010, 0, 8'h22, 0);
        add(1, 8'h33, 3'b000, 3'b111, 0, 3'b010, 0, 8'h33, 0);
        add(1, 8'h0D, 3'b000, 3'b111, 0, 3'b010, 0, 8'h0D, 0);
        add(0, 8'h00, 3'b000, 3'b111, 1, 3'b000, 0, 8'h00, 0);
        add(0, 8'h00, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);
        // Packet 2: same, bad parity 0x00
        add(1, 8'h0D, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);
        add(1, 8'h11, 3'b000, 3'b111, 1, 3'b000, 0, 8'h00, 0);
        add(1, 8'h11, 3'b000, 3'b111, 1, 3'b010, 1, 8'h0D, 0);
        add(1, 8'h11, 3'b000, 3'b111, 0, 3'b010, 0, 8'h11, 0);
        add(1, 8'h22, 3'b000, 3'b111, 0, 3'b010, 0, 8'h22, 0);
        add(1, 8'h33, 3'b000, 3'b111, 0, 3'b010, 0, 8'h33, 0);
        add(1, 8'h00, 3'b000, 3'b111, 0, 3'b010, 0, 8'h00, 0);
        add(0, 8'h00, 3'b000, 3'b111, 1, 3'b000, 0, 8'h00, 1);
        add(0, 8'h00, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);
        // Packet 3: port 2 not empty at header; LEN 2, parity 0x19
        add(1, 8'h0A, 3'b000, 3'b011, 0, 3'b000, 0, 8'h00, 0);
        add(1, 8'hA1, 3'b000, 3'b011, 1, 3'b000, 0, 8'h00, 0);
        add(1, 8'hA1, 3'b000, 3'b011, 1, 3'b000, 0, 8'h00, 0);
        add(1, 8'hA1, 3'b000, 3'b111, 1, 3'b000, 0, 8'h00, 0);
        add(1, 8'hA1, 3'b000, 3'b111, 1, 3'b100, 1, 8'h0A, 0);
        add(1, 8'hA1, 3'b000, 3'b111, 0, 3'b100, 0, 8'hA1, 0);
        add(1, 8'hB2, 3'b000, 3'b111, 0, 3'b100, 0, 8'hB2, 0);
        add(1, 8'h19, 3'b000, 3'b111, 0, 3'b100, 0, 8'h19, 0);
        add(0, 8'h00, 3'b000, 3'b111, 1, 3'b000, 0, 8'h00, 0);
        add(0, 8'h00, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);
        // Packet 4 (index 28..40): port 0, LEN 3, full[0] for 4 cycles on 2nd payload byte
        add(1, 8'h0C, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);
        add(1, 8'h01, 3'b000, 3'b111, 1, 3'b000, 0, 8'h00, 0);
        add(1, 8'h01, 3'b000, 3'b111, 1, 3'b001, 1, 8'h0C, 0);
        add(1, 8'h01, 3'b000, 3'b111, 0, 3'b001, 0, 8'h01, 0);
        for (int k = 0; k < 4; k++) add(1, 8'h02, 3'b001, 3'b111, 1, 3'b000, 0, 8'h00, 0);
        add(1, 8'h02, 3'b000, 3'b111, 0, 3'b001, 0, 8'h02, 0);
        add(1, 8'h03, 3'b000, 3'b111, 0, 3'b001, 0, 8'h03, 0);
        add(1, 8'h0C, 3'b000, 3'b111, 0, 3'b001, 0, 8'h0C, 0);
        add(0, 8'h00, 3'b000, 3'b111, 1, 3'b000, 0, 8'h00, 0);
        add(0, 8'h00, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);
        // Invalid destination header 0x07: dropped, controller stays idle
        add(1, 8'h07, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);
        add(0, 8'h00, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);
        add(0, 8'h00, 3'b000, 3'b111, 0, 3'b000, 0, 8'h00, 0);

        bus.pkt_valid = 1'b0;
        bus.data_in   = 8'h00;
        bus.full      = 3'b000;
        bus.empty     = 3'b111;
        bus.read_enb  = 3'b000;
        resetn        = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("reset_outputs",
              {bus.busy, bus.err, bus.write_enb, bus.lfd_state, bus.soft_reset}, 9'd0);
        check("reset_state", dut.state_q, StIdle);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        wr = 0;
        for (int i = 0; i < nvec; i++) begin
            apply(i, we_obs);
            if (i >= 28 && i <= 40 && we_obs != 3'b000) wr++;
        end
        check("full_stall_total_writes", wr, 5);

        // Reset in the middle of a payload
        for (int i = 0; i < 4; i++) apply(i, we_obs);
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h22;
        #1;
        check("pre_reset_payload_write", bus.write_enb, 3'b010);
        resetn = 1'b0;
        #1;
        check("midpkt_reset_outputs",
              {bus.busy, bus.err, bus.write_enb, bus.lfd_state, bus.soft_reset}, 9'd0);
        check("midpkt_reset_state", dut.state_q, StIdle);
        bus.pkt_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 9; i++) apply(i, we_obs);

        // Unread timeout on port 0, without and with an intervening read
        run_timeout("timeout", 0, 31, 45);
        run_timeout("timeout_rd", 20, 51, 70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
